serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 134 +++++++++++++
 tb/tb_serial_mag_comparator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from
// the MSB end and stops at the first differing chunk, giving one-hot A<B / A==B / A>B flags.
module serial_mag_comparator #(
   parameter int WIDTH     = 8,
   parameter int CHUNK     = 2,
   parameter int SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_less_B,
   output logic             A_equal_B,
   output logic             A_greater_B
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [IDX_W-1:0]   idx_r;
   logic               signed_mode_s;
   logic [CHUNK-1:0]   a_chunk_s;
   logic [CHUNK-1:0]   b_chunk_s;
   logic               chunk_gt_s;
   logic               chunk_lt_s;
   logic               last_chunk_s;
   logic               accept_s;

   // Flipping the sign bit maps two's-complement ordering onto unsigned ordering.
   function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v, input logic flip);
      return v ^ {flip, {(WIDTH-1){1'b0}}};
   endfunction

   // Effective signed mode, acceptance strobe and current chunk comparison.
   always_comb begin
      signed_mode_s = 1'b0;
      if (SIGNED_EN != 0) begin
         signed_mode_s = is_signed;
      end else begin
         signed_mode_s = 1'b0;
      end
      accept_s     = (state_r == IDLE) && start;
      a_chunk_s    = a_r[int'(idx_r)*CHUNK +: CHUNK];
      b_chunk_s    = b_r[int'(idx_r)*CHUNK +: CHUNK];
      chunk_gt_s   = (a_chunk_s > b_chunk_s);
      chunk_lt_s   = (a_chunk_s < b_chunk_s);
      last_chunk_s = (idx_r == {IDX_W{1'b0}});
   end

   // Operand and chunk-index datapath; reloaded on every accepted start.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         a_r   <= bias_msb(A, signed_mode_s);
         b_r   <= bias_msb(B, signed_mode_s);
         idx_r <= IDX_W'(N - 1);
      end else if ((state_r == CMP) && !chunk_gt_s && !chunk_lt_s && !last_chunk_s) begin
         idx_r <= idx_r - IDX_W'(1);
      end else begin
         idx_r <= idx_r;
      end
   end

   // Control FSM with registered status and result flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         A_less_B    <= 1'b0;
         A_equal_B   <= 1'b0;
         A_greater_B <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r     <= CMP;
                  busy        <= 1'b1;
                  A_less_B    <= 1'b0;
                  A_equal_B   <= 1'b0;
                  A_greater_B <= 1'b0;
               end else begin
                  busy <= 1'b0;
               end
            end
            CMP: begin
               if (chunk_gt_s) begin
                  A_greater_B <= 1'b1;
                  state_r     <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else if (chunk_lt_s) begin
                  A_less_B <= 1'b1;
                  state_r  <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else if (last_chunk_s) begin
                  A_equal_B <= 1'b1;
                  state_r   <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  busy <= 1'b1;
                  done <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator: table vectors, random ops against a
// reference model, and hand sequences for ignored start, mid-op reset and a 16/4 build.
module tb_serial_mag_comparator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [7:0]  a = 8'h00;
   logic [7:0]  b = 8'h00;
   logic        busy, done, lt, eq, gt;

   logic        start2 = 1'b0;
   logic        sgn2 = 1'b0;
   logic [15:0] a2 = 16'h0000;
   logic [15:0] b2 = 16'h0000;
   logic        busy2, done2, lt2, eq2, gt2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sgn;
      int         lat;
      logic       lt;
      logic       eq;
      logic       gt;
   } vec_t;

   typedef struct {
      int   cyc;
      logic lt;
      logic eq;
      logic gt;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];

   serial_mag_comparator #(.WIDTH(8), .CHUNK(2), .SIGNED_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .A(a), .B(b),
      .busy(busy), .done(done), .A_less_B(lt), .A_equal_B(eq), .A_greater_B(gt)
   );

   serial_mag_comparator #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(0)) dut16 (
      .clk(clk), .rst(rst), .start(start2), .is_signed(sgn2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .A_less_B(lt2), .A_equal_B(eq2), .A_greater_B(gt2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("flags", {29'd0, lt, eq, gt}, {29'd0, e.lt, e.eq, e.gt});
            check("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic s,
                                 output int lat, output logic mlt, output logic meq, output logic mgt);
      logic [7:0] x, y;
      x = av; y = bv;
      if (s) begin
         x[7] = ~x[7];
         y[7] = ~y[7];
      end
      lat = 4; mlt = 1'b0; meq = 1'b1; mgt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (x[7-2*k -: 2] != y[7-2*k -: 2]) begin
            lat = k + 1;
            meq = 1'b0;
            mlt = (x[7-2*k -: 2] < y[7-2*k -: 2]);
            mgt = !mlt;
            break;
         end
      end
   endfunction

   task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input int lat, input logic elt, input logic eeq, input logic egt);
      @(negedge clk);
      a = av; b = bv; is_signed = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back('{cyc + lat, elt, eeq, egt});
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input int lat, input logic elt, input logic eeq, input logic egt);
      launch(av, bv, s, lat, elt, eeq, egt);
      @(negedge clk);
      check("busy_in_cmp", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
      check("flags_cleared", {29'd0, lt, eq, gt}, 32'd0);
      wait_done();
   endtask

   initial begin
      int   rlat;
      logic rlt, req, rgt;
      logic [7:0] ra, rb;
      logic rs;

      vecs[0]  = '{8'hA5, 8'hA5, 1'b0, 4, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{8'h80, 8'h7F, 1'b0, 1, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{8'h80, 8'h7F, 1'b1, 1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{8'h12, 8'h13, 1'b0, 4, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{8'hFE, 8'hFF, 1'b1, 4, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{8'h00, 8'h00, 1'b1, 4, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{8'h7F, 8'h80, 1'b1, 1, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{8'h34, 8'h30, 1'b0, 3, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{8'h24, 8'h28, 1'b0, 3, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{8'hC0, 8'h80, 1'b1, 1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{8'h10, 8'h20, 1'b0, 2, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{8'hFF, 8'hFF, 1'b0, 4, 1'b0, 1'b1, 1'b0};

      #2;
      check("reset_outputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lat, vecs[i].lt, vecs[i].eq, vecs[i].gt);
      end

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = (i % 4 == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rs, rlat, rlt, req, rgt);
         run_op(ra, rb, rs, rlat, rlt, req, rgt);
      end

      // start while busy is dropped; flags must hold afterwards
      launch(8'h40, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      a = 8'h00; b = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      repeat (5) @(negedge clk);
      check("flags_hold", {28'd0, done, lt, eq, gt}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});

      // reset mid-comparison aborts without a done pulse
      @(negedge clk);
      a = 8'h01; b = 8'h02; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      check("busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_outputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      run_op(8'h03, 8'h03, 1'b0, 4, 1'b0, 1'b1, 1'b0);

      // 16-bit, 4-bit chunk build with signed mode disabled
      for (int t = 0; t < 2; t++) begin
         int c0;
         int seen;
         @(negedge clk);
         a2 = (t == 0) ? 16'h8000 : 16'h1234;
         b2 = (t == 0) ? 16'h0001 : 16'h1234;
         sgn2 = 1'b1; start2 = 1'b1;
         @(posedge clk);
         #1;
         start2 = 1'b0;
         c0 = cyc;
         seen = 0;
         for (int i = 0; i < 12 && seen == 0; i++) begin
            @(negedge clk);
            if (done2 === 1'b1) seen = cyc - c0;
         end
         check("w16_latency", seen, (t == 0) ? 32'd1 : 32'd4);
         check("w16_flags", {29'd0, lt2, eq2, gt2}, (t == 0) ? 32'b001 : 32'b010);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
